// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle subtract datapath: widths and FSM state encoding.
package alu_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int HALF_DEF  = WIDTH_DEF / 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LO   = 2'd1;
    localparam state_t ST_HI   = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic int half_of(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/rsa32.sv
// Combinational ripple-borrow subtractor slice: diff = x - y - bi, one full-subtractor cell per bit.
module rsa32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] diff,
    output logic         bo
);

    logic [W:0] brw;

    assign brw[0] = bi;

    for (genvar i = 0; i < W; i++) begin : g_cell
        // Borrow out when x < y + borrow_in at this bit position.
        assign diff[i]    = x[i] ^ y[i] ^ brw[i];
        assign brw[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
    end

    assign bo = brw[W];

endmodule

// File: rtl/seq_sub64.sv
// Two-cycle subtractor d = a - b - bin sharing one half-width borrow slice, with start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start
// LO    | low half through the slice
// HI    | high half through the slice, results registered
// DONE  | done pulse, results valid; start here issues back-to-back
module seq_sub64
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int HALF = half_of(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic             bin_q;
    logic [HALF-1:0]  lo_q;
    logic             brw_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q, zero_q, ovf_q;

    logic             accept;
    logic             in_hi;
    logic [HALF-1:0]  slice_x, slice_y, slice_diff;
    logic             slice_bi, slice_bo;

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_hi  = (state_q == ST_HI);

    assign slice_x  = in_hi ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
    assign slice_y  = in_hi ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
    assign slice_bi = in_hi ? brw_q : bin_q;

    rsa32 #(.W(HALF)) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .bi   (slice_bi),
        .diff (slice_diff),
        .bo   (slice_bo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_LO : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bin_q   <= 1'b0;
            lo_q    <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                bin_q <= bin;
            end
            if (state_q == ST_LO) begin
                lo_q  <= slice_diff;
                brw_q <= slice_bo;
            end
            // Results only move on the HI edge so they stay readable until the next op completes.
            if (in_hi) begin
                d_q    <= {slice_diff, lo_q};
                bout_q <= slice_bo;
                zero_q <= ({slice_diff, lo_q} == '0);
                ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_diff[HALF-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign busy = (state_q == ST_LO) || (state_q == ST_HI);
    assign done = (state_q == ST_DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_sub64.sv
// Directed-vector bench for seq_sub64: table of subtractions plus handshake and reset sequences.
module tb_seq_sub64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a, b;
    logic        bin;
    logic        busy, done;
    logic [63:0] d;
    logic        bout, zero, ovf;

    int errors = 0;
    int checks = 0;

    seq_sub64 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op from a negedge and checks busy/done timing and the registered results.
    task automatic do_op(input vec_t v);
        @(negedge clk);
        start = 1'b1; a = v.a; b = v.b; bin = v.bin;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({v.name, " busy LO"}, 64'(busy), 64'd1);
        check({v.name, " done LO"}, 64'(done), 64'd0);
        @(negedge clk);
        check({v.name, " busy HI"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({v.name, " done"}, 64'(done), 64'd1);
        check({v.name, " busy DONE"}, 64'(busy), 64'd0);
        check({v.name, " d"}, d, v.d);
        check({v.name, " bout"}, 64'(bout), 64'(v.bout));
        check({v.name, " zero"}, 64'(zero), 64'(v.zero));
        check({v.name, " ovf"}, 64'(ovf), 64'(v.ovf));
        @(negedge clk);
        check({v.name, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_seen;
        vec_t v;

        vecs[0] = '{"5-3",        64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"0-1",        64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"1-0-1",      64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"cross",      64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"minint-1",   64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"maxint+1",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"0-0-1",      64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{"cross bin",  64'h0000_0001_0000_0000, 64'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"min-min",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset d", d, 64'd0);
        check("reset flags", {61'd0, bout, zero, ovf}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // start held high through LO/HI must not disturb 10-4, then issues 99-1 from DONE.
        @(negedge clk);
        start = 1'b1; a = 64'd10; b = 64'd4; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 64'd99; b = 64'd1;
        check("hs busy LO", 64'(busy), 64'd1);
        @(negedge clk);
        check("hs busy HI", 64'(busy), 64'd1);
        @(negedge clk);
        check("hs done1", 64'(done), 64'd1);
        check("hs d1", d, 64'd6);
        @(negedge clk);
        start = 1'b0;
        check("hs b2b busy", 64'(busy), 64'd1);
        check("hs b2b no done", 64'(done), 64'd0);
        check("hs d hold", d, 64'd6);
        @(negedge clk);
        check("hs d hold HI", d, 64'd6);
        @(negedge clk);
        check("hs done2", 64'(done), 64'd1);
        check("hs d2", d, 64'd98);
        @(negedge clk);

        // Reset during HI discards 7-2 and clears outputs at once.
        @(negedge clk);
        start = 1'b1; a = 64'd7; b = 64'd2; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst pre busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst d", d, 64'd0);
        check("rst flags", {61'd0, bout, zero, ovf}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("rst no done", 64'(done_seen), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        v = '{"post-rst 7-2", 64'd7, 64'd2, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0};
        do_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_sub64.md
# seq_sub64

Multi-cycle 64-bit subtractor with borrow-in, computing `d = a - b - bin` over two cycles through one shared 32-bit ripple-borrow slice. It is the subtract-direction counterpart to the datapath's 64-bit ripple-carry adder. It trades latency for half the ripple depth and adds a start/busy/done handshake so a controller can issue subtractions and comparisons. It reports unsigned borrow, signed overflow and zero flags for branch/compare logic.

## Interface
- `WIDTH`, default 64: operand width; must be even; `HALF = WIDTH/2` is the slice width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; sampled with `start`.
- `b`  in  WIDTH  subtrahend; sampled with `start`.
- `bin`  in  1  borrow-in; sampled with `start`.
- `busy`  out  1  high in LO and HI states.
- `done`  out  1  one-cycle pulse; results valid.
- `d`  out  WIDTH  difference, modulo 2^WIDTH.
- `bout`  out  1  unsigned borrow-out. 1 iff `a < b + bin` (unsigned).
- `zero`  out  1  `d == 0`.
- `ovf`  out  1  signed overflow: `(a[MSB] != b[MSB]) && (d[MSB] != a[MSB])`.

## Operation
- The block is clocked by `clk`. Reset is asynchronous and active-high on `rst`.
- FSM states: IDLE, LO, HI, DONE. Encoding is 2 bits.
- IDLE: `start=1` latches `a`, `b`, `bin` into internal registers, then goes to LO. With `start=0` it stays in IDLE.
- LO: slice computes `a[HALF-1:0] - b[HALF-1:0] - bin`. Low difference goes to `lo_q`, slice borrow to `brw_q`. Next state is HI.
- HI: slice computes `a[WIDTH-1:HALF] - b[WIDTH-1:HALF] - brw_q`.
  - `d` is registered as `{hi, lo_q}`, together with `bout`, `zero` and `ovf`.
  - Next state is DONE.
- DONE: `done=1`.
  - With `start=1`, new operands are latched and the next state is LO (back-to-back issue; no idle bubble).
  - Otherwise the next state is IDLE.
- `start` in LO or HI is ignored. Operands are not re-sampled, and the in-flight result is unaffected.
- `d`, `bout`, `zero` and `ovf` change only at the HI edge. They hold the last result until the next operation's HI edge.
- Internal arithmetic is pure two's-complement, with no saturation. `bin` participates only in the low half.
- `rst` asserted in any state:
  - state goes to IDLE immediately;
  - `busy`, `done`, `d`, `bout`, `zero`, `ovf`, the operand registers, `lo_q` and `brw_q` all go to 0;
  - any in-flight operation is discarded, and no `done` is issued for it.
- Reset values: `busy=0`, `done=0`, `d=0`, `bout=0`, `zero=0`, `ovf=0`.

## Timing
- E0: `start` sampled high in IDLE or DONE, operands captured.
- E1: low half computed.
- E2: high half computed; results registered.
- `done` is high for exactly the cycle between E2 and E3.
- Latency: 3 rising edges from the `start` sample to the end of the `done` cycle. Results are readable in the same cycle `done` is high.
- Throughput: one operation per 3 cycles with continuous `start`.
- `busy` is high in the cycles between E0 and E2. It is low during DONE.
- The critical path is one HALF-bit ripple plus the flag logic. `zero` is computed from `{hi, lo_q}` in HI.

## Structure
- Shared package `alu_pkg` holds:
  - the state typedef (IDLE/LO/HI/DONE);
  - the `WIDTH` default constant, 64;
  - the `HALF` derivation.
- Sub-module `rsa32`: combinational HALF-bit ripple-borrow subtractor with ports `diff`, `bo`, `x`, `y`, `bi`. It is built from a full-subtractor cell per bit. Exactly one instance is used, muxed between the low and high halves by state.
- Top module contains the FSM, operand registers, `lo_q`/`brw_q`, the result registers and the flag logic.

## Test plan
- Basic subtraction: `a=5`, `b=3`, `bin=0`, `start` pulsed.
  - Expect `busy=1` for 2 cycles, then `done=1` for 1 cycle.
  - Expect `d=2`, `bout=0`, `zero=0`, `ovf=0`.
- Unsigned underflow: `a=0`, `b=1`, `bin=0`.
  - Expect `d=0xFFFF_FFFF_FFFF_FFFF`, `bout=1`, `ovf=0`.
  - Repeat with `a=1`, `b=0`, `bin=1`: expect `d=0`, `zero=1`, `bout=0`.
- Cross-half borrow: `a=0x0000_0001_0000_0000`, `b=1`.
  - Expect `d=0x0000_0000_FFFF_FFFF`, `bout=0`.
- Signed overflow: `a=0x8000_0000_0000_0000`, `b=1`.
  - Expect `d=0x7FFF_FFFF_FFFF_FFFF`, `ovf=1`, `bout=0`.
  - Then `a=0x7FFF_FFFF_FFFF_FFFF`, `b=0xFFFF_FFFF_FFFF_FFFF`: expect `d=0x8000_0000_0000_0000`, `ovf=1`, `bout=1`.
- Handshake:
  - Start op `10-4`. Hold `start=1` with operands `99-1` through LO and HI. Expect `d=6`; the held operands are not captured mid-flight.
  - `start` still high in DONE starts `99-1`. Expect the next `done` 3 cycles later with `d=98`.
- Reset mid-operation: start `7-2` and assert `rst` during HI.
  - Expect all outputs 0 immediately and no `done` pulse.
  - After deassert, an op `7-2` yields `d=5`.
